vx_ram_rmw_ctrl: RTL

//  Request sequencer in front of VX_sp_ram (OUT_REG=0, 1-cycle read latency); drives its read/write/wren/addr/wdata.

---
 rtl/vx_ram_rmw_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vx_ram_rmw_ctrl.sv
// vx_ram_rmw_ctrl: request sequencer in front of a 1-cycle-latency single-port RAM.
// Handles READ, WRITE and atomic fetch-ADD requests, with an optional post-reset clear sweep.
// Ports: clk, reset (sync, active-high), init_done (sweep finished);
//   req_valid/req_ready/req_op/req_addr/req_data/req_wren = request channel;
//   rsp_valid/rsp_ready/rsp_data = response channel (READ data or pre-add value);
//   ram_read/ram_write/ram_wren/ram_addr/ram_wdata/ram_rdata = RAM side.
// Optional: define RAM_RMW_PERF_EN to add perf_add_count (count of ADD write-backs).
module vx_ram_rmw_ctrl #(
    parameter int DATAW                  = 32,
    parameter int SIZE                   = 256,
    parameter int WRENW                  = 4,
    parameter int INIT_ENABLE            = 1,
    parameter logic [DATAW-1:0] INIT_VALUE = '0,
    parameter int ADDRW                  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             init_done,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_data,
    input  logic [WRENW-1:0] req_wren,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [DATAW-1:0] rsp_data,
    input  logic             rsp_ready,
    output logic             ram_read,
    output logic             ram_write,
    output logic [WRENW-1:0] ram_wren,
    output logic [ADDRW-1:0] ram_addr,
    output logic [DATAW-1:0] ram_wdata,
    input  logic [DATAW-1:0] ram_rdata
`ifdef RAM_RMW_PERF_EN
    ,
    output logic [31:0]      perf_add_count
`endif
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD,
        WB,
        RSP
    } state_e;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

    state_e           state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [DATAW-1:0] opnd_q, opnd_d;
    logic [DATAW-1:0] data_q, data_d;
    logic             add_q, add_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            opnd_q  <= '0;
            data_q  <= '0;
            add_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            opnd_q  <= opnd_d;
            data_q  <= data_d;
            add_q   <= add_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        opnd_d    = opnd_q;
        data_d    = data_q;
        add_d     = add_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_wren  = '0;
        ram_addr  = '0;
        ram_wdata = '0;

        unique case (state_q)
            INIT: begin
                if (INIT_ENABLE != 0) begin
                    ram_write = 1'b1;
                    ram_wren  = '1;
                    ram_addr  = cnt_q;
                    ram_wdata = INIT_VALUE;
                    cnt_d     = cnt_q + ADDRW'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
                ram_addr  = req_addr;
                ram_wdata = req_data;
                if (req_valid) begin
                    unique case (req_op)
                        OP_READ: begin
                            ram_read = 1'b1;
                            addr_d   = req_addr;
                            add_d    = 1'b0;
                            state_d  = RD;
                        end
                        OP_WRITE: begin
                            ram_write = 1'b1;
                            ram_wren  = req_wren;
                        end
                        OP_ADD: begin
                            ram_read = 1'b1;
                            addr_d   = req_addr;
                            opnd_d   = req_data;
                            add_d    = 1'b1;
                            state_d  = RD;
                        end
                        default: ;
                    endcase
                end
            end
            RD: begin
                data_d  = ram_rdata;
                state_d = add_q ? WB : RSP;
            end
            WB: begin
                // data_q keeps the pre-add value for the response
                ram_write = 1'b1;
                ram_wren  = '1;
                ram_addr  = addr_q;
                ram_wdata = data_q + opnd_q;
                state_d   = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase

        // Outputs are combinational, so hold them quiet while reset is high
        if (reset) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            ram_read  = 1'b0;
            ram_write = 1'b0;
            ram_wren  = '0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    assign init_done = !reset && (state_q != INIT);
    assign rsp_data  = data_q;

`ifdef RAM_RMW_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state_q == WB) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_add_count = perf_q;
`endif

endmodule
